interrupt_controller: RTL
=========================

# interrupt_controller

Upstream interrupt source for the CPU control unit. Captures rising edges on `NUM_IRQ` external lines into a pending register and applies a mask. Raises `int_req` for the highest-priority unmasked pending line and supplies its handler address on `int_addr`. Tracks one in-service interrupt, cleared by the control unit's `int_ack_attended` / `int_ack_complete` pulses. Non-nesting.

## Interface
Parameters:
- `NUM_IRQ`, 8: number of interrupt lines, 1..16.
- `ADDR_W`, 32: handler address width.
- `VEC_BASE`, 32'h0000_0100: address of handler 0.
- `VEC_STRIDE`, 4: address spacing between handlers.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset (synchronous, active-high).
- `irq_in`  in  NUM_IRQ  external interrupt lines; a rising edge creates a request.
- `irq_mask`  in  NUM_IRQ  1 = line enabled; sampled every cycle.
- `int_ack_attended`  in  1  one-cycle pulse: the CPU has entered the handler.
- `int_ack_complete`  in  1  one-cycle pulse: the CPU executed RETI.
- `int_req`  out  1  request to the control unit.
- `int_addr`  out  ADDR_W  handler address = `VEC_BASE + int_id*VEC_STRIDE`.
- `int_id`  out  ID_W  selected line index, where ID_W = max(1, clog2(NUM_IRQ)).
- `irq_pending`  out  NUM_IRQ  pending register.
- `in_service`  out  1  a handler is active.

## Operation
- Edge capture, every cycle: `pending <= (pending & ~clr) | (irq_in & ~irq_prev)`, then `irq_prev <= irq_in`.
  - `clr` is the one-hot of `int_id` when an ack is taken.
  - If a set and a clear hit the same bit in the same cycle, the set wins; the bit stays pending.
- Selection: the lowest index among `pending & irq_mask` has the highest priority.
- FSM states: IDLE, REQUEST, SERVICE.
- IDLE:
  - If `pending & irq_mask` ≠ 0, latch the winning index into `int_id` and go to REQUEST.
- REQUEST:
  - `int_req` = 1.
  - `int_id` and `int_addr` are frozen: a later higher-priority edge or a mask change does not retract or alter the request.
  - On `int_ack_attended`: clear that pending bit, drop `int_req`, go to SERVICE.
- SERVICE:
  - `in_service` = 1; `int_req` = 0; `int_id` and `int_addr` are held.
  - New edges still accumulate in `pending`.
  - On `int_ack_complete`: go to IDLE.
- Stray pulses are ignored: `int_ack_attended` outside REQUEST, and `int_ack_complete` outside SERVICE.
- Masked pending bits stay pending. They are served once unmasked.
- Address arithmetic is done in ADDR_W bits, unsigned, with wrap-around modulo 2^ADDR_W.

## Timing
- Reset values: `int_req` = 0, `in_service` = 0, `int_id` = 0, `int_addr` = VEC_BASE, `irq_pending` = 0, internal `irq_prev` = 0, FSM state = IDLE.
- Reset mid-request or mid-service returns the block to IDLE and discards all pending bits.
- All outputs are registered.
- Latency: an edge first sampled at clock edge k sets `pending` after k. `int_req` is high after k+1, so there are 2 cycles from the sampled edge to the request.
- `int_req` deasserts on the clock edge that samples `int_ack_attended`.
- After `int_ack_complete`, the earliest next `int_req` is 1 cycle later (IDLE → REQUEST).
- A line held high produces exactly one request per rising edge.

## Configuration
- `IRQ_SYNC_EN`, defined: `irq_in` passes through a 2-flop synchronizer per line before edge detection. Latency rises to 4 cycles. The synchronizer flops reset to 0.
- `IRQ_SYNC_EN`, undefined: `irq_in` is assumed synchronous to `clk` and is used directly. Latency is 2 cycles.

## Structure
- Shared package `ic_pkg`:
  - FSM state encoding (IDLE = 2'd0, REQUEST = 2'd1, SERVICE = 2'd2).
  - Defaults for `VEC_BASE` and `VEC_STRIDE`.
  - The ID_W helper function.
- One sub-module, `irq_priority_enc`: combinational lowest-index-first encoder. Outputs a `valid` flag and an index.

## Test plan
- Single IRQ: pulse `irq_in[3]` with mask 8'hFF.
  - `int_req` is high 2 cycles later, `int_id` = 3, `int_addr` = 32'h10C.
  - Ack attended → `int_req` = 0, `in_service` = 1.
  - Ack complete → IDLE.
- Priority: edges on lines 5 and 2 in the same cycle.
  - Line 2 is served first (`int_addr` = 32'h108).
  - After complete, line 5 is requested (32'h114) 1 cycle later.
- Mask: edge on line 1 with `irq_mask[1]` = 0 → no `int_req`, `irq_pending[1]` = 1.
  - Set `mask[1]` = 1 → request within 1 cycle, `int_id` = 1.
- No preemption: while in REQUEST for line 6, raise line 0.
  - `int_id` stays 6 until the ack.
  - Line 0 is requested after `int_ack_complete`.
- Re-trigger and stray acks:
  - An edge on line 4 in the same cycle as its attended ack leaves `pending[4]` = 1.
  - A stray `int_ack_complete` in IDLE causes no state change.
- Reset mid-service: assert `rst` in SERVICE.
  - All outputs take their reset values next cycle; `int_addr` = 32'h100.

Source files
------------

// File: rtl/ic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ic_pkg
// Brief    : Shared types, defaults and helpers for the interrupt controller.
// Revision : 1.0 - initial release
// ============================================================================
package ic_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        SERVICE = 2'd2
    } ic_state_t;

    localparam logic [31:0] C_VEC_BASE   = 32'h0000_0100;
    localparam int          C_VEC_STRIDE = 4;

    // Index width; a single line still needs one bit for int_id.
    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/irq_priority_enc.sv
`default_nettype none
// ============================================================================
// Module   : irq_priority_enc
// Brief    : Combinational lowest-index-first priority encoder.
// Revision : 1.0 - initial release
// ============================================================================
module irq_priority_enc
    import ic_pkg::*;
#(
    parameter int N    = 8,
    parameter int ID_W = id_width(N)
) (
    input  logic [N-1:0]    req,
    output logic            valid,
    output logic [ID_W-1:0] idx
);

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        // Scan downwards so the lowest set index is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = ID_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module   : interrupt_controller
// Brief    : Edge-capturing, non-nesting vectored interrupt controller.
//            Define IRQ_SYNC_EN to add a 2-flop synchronizer on irq_in.
// Revision : 1.0 - initial release
// ============================================================================
module interrupt_controller
    import ic_pkg::*;
#(
    parameter int               NUM_IRQ    = 8,
    parameter int               ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] VEC_BASE  = ADDR_W'(C_VEC_BASE),
    parameter int               VEC_STRIDE = C_VEC_STRIDE,
    localparam int              ID_W       = id_width(NUM_IRQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_IRQ-1:0]  irq_in,
    input  logic [NUM_IRQ-1:0]  irq_mask,
    input  logic                int_ack_attended,
    input  logic                int_ack_complete,
    output logic                int_req,
    output logic [ADDR_W-1:0]   int_addr,
    output logic [ID_W-1:0]     int_id,
    output logic [NUM_IRQ-1:0]  irq_pending,
    output logic                in_service
);

    ic_state_t          r_state, w_next_state;
    logic [NUM_IRQ-1:0] w_irq;
    logic [NUM_IRQ-1:0] r_irq_prev;
    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] w_clr;
    logic [ID_W-1:0]    r_int_id, w_next_id;
    logic [ADDR_W-1:0]  r_int_addr, w_next_addr;
    logic               r_int_req, r_in_service;
    logic               w_take;
    logic               w_valid;
    logic [ID_W-1:0]    w_idx;

`ifdef IRQ_SYNC_EN
    logic [NUM_IRQ-1:0] r_sync_q1, r_sync_q2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_q1 <= '0;
            r_sync_q2 <= '0;
        end else begin
            r_sync_q1 <= irq_in;
            r_sync_q2 <= r_sync_q1;
        end
    end

    assign w_irq = r_sync_q2;
`else
    assign w_irq = irq_in;
`endif

    irq_priority_enc #(
        .N    (NUM_IRQ),
        .ID_W (ID_W)
    ) u_enc (
        .req   (r_pending & irq_mask),
        .valid (w_valid),
        .idx   (w_idx)
    );

    always_comb begin
        w_next_state = r_state;
        w_next_id    = r_int_id;
        w_next_addr  = r_int_addr;
        w_take       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_valid) begin
                    w_next_state = REQUEST;
                    w_next_id    = w_idx;
                    w_next_addr  = VEC_BASE + ADDR_W'(w_idx) * ADDR_W'(VEC_STRIDE);
                end
            end
            REQUEST: begin
                if (int_ack_attended) begin
                    w_next_state = SERVICE;
                    w_take       = 1'b1;
                end
            end
            SERVICE: begin
                if (int_ack_complete) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_clr = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            w_clr[i] = w_take && (r_int_id == ID_W'(i));
        end
    end

    // The set term is OR-ed after the clear so a same-cycle edge survives the ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_irq_prev   <= '0;
            r_pending    <= '0;
            r_int_id     <= '0;
            r_int_addr   <= VEC_BASE;
            r_int_req    <= 1'b0;
            r_in_service <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_irq_prev   <= w_irq;
            r_pending    <= (r_pending & ~w_clr) | (w_irq & ~r_irq_prev);
            r_int_id     <= w_next_id;
            r_int_addr   <= w_next_addr;
            r_int_req    <= (w_next_state == REQUEST);
            r_in_service <= (w_next_state == SERVICE);
        end
    end

    assign int_req     = r_int_req;
    assign in_service  = r_in_service;
    assign int_id      = r_int_id;
    assign int_addr    = r_int_addr;
    assign irq_pending = r_pending;

endmodule
`default_nettype wire
